// File: rtl/sigmoid_deriv_sched.sv
// Round-robin scheduler that shares one fixed-latency sigmoid-derivative unit
// between NREQ requesters. Operands go out on unit_in and results come back on
// unit_out LAT cycles later. A tag pipeline routes each result to the requester
// that issued the operand.
module sigmoid_deriv_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          unit_in,
  input  logic [31:0]          unit_out,
  output logic [NREQ-1:0]      res_valid,
  output logic [31:0]          res_data,
  output logic                 busy,
  output logic                 flush_done
);

  localparam int unsigned PtrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW  = $clog2(LAT + 2);
  // Stage 0 launches together with unit_in; the remaining LAT stages match the
  // unit's latency, so the last stage lines up with the matching unit_out.
  localparam int unsigned Depth = LAT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [PtrW-1:0]              ptr_q, ptr_d;
  logic [Depth-1:0]             vld_q, vld_d;
  logic [Depth-1:0][PtrW-1:0]   tag_q, tag_d;
  logic [CntW-1:0]              inflight_q, inflight_d;
  logic [31:0]                  unit_in_q, unit_in_d;
  logic [31:0]                  res_data_q, res_data_d;
  logic [NREQ-1:0]              res_valid_q, res_valid_d;
  logic                         flush_done_q, flush_done_d;

  logic [PtrW-1:0]              win;
  logic [PtrW-1:0]              cand;
  logic                         found;
  logic                         xfer;
  logic                         done;

  // Round-robin search starting at ptr; grants only while running and not flushing.
  always_comb begin
    gnt   = '0;
    win   = '0;
    cand  = '0;
    found = 1'b0;
    if (state_q == StRun && en && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = PtrW'((32'(ptr_q) + 32'(k)) % NREQ);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) gnt[win] = 1'b1;
    end
  end

  assign xfer = |(req & gnt);
  assign done = vld_q[Depth-1];

  // Datapath next state: pointer, operand register, tag pipeline, result, inflight.
  always_comb begin
    ptr_d       = ptr_q;
    unit_in_d   = unit_in_q;
    res_data_d  = res_data_q;
    res_valid_d = '0;
    inflight_d  = inflight_q;
    vld_d       = {vld_q[Depth-2:0], xfer};
    tag_d       = {tag_q[Depth-2:0], win};
    if (xfer) begin
      ptr_d     = (32'(win) == NREQ - 1) ? '0 : PtrW'(win + 1'b1);
      unit_in_d = req_data[32*win +: 32];
    end
    if (done) begin
      res_data_d                 = unit_out;
      res_valid_d[tag_q[Depth-1]] = 1'b1;
    end
    // A simultaneous issue and completion leaves the count unchanged.
    unique case ({xfer, done})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Control FSM: drain waits for every in-flight result before leaving.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (flush || !en) state_d = StDrain;
      StDrain: begin
        if (inflight_q == '0) begin
          flush_done_d = 1'b1;
          state_d      = en ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops every in-flight tag so stale results never strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      vld_q        <= '0;
      tag_q        <= '0;
      inflight_q   <= '0;
      unit_in_q    <= '0;
      res_data_q   <= '0;
      res_valid_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      vld_q        <= vld_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      unit_in_q    <= unit_in_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign unit_in    = unit_in_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != StIdle) || (inflight_q != '0);

endmodule
